multi_channel_spi_sensor: RTL and testbench

- SPI mode-0 slave emulating a multi-channel sensor with readable and writable registers. Generalises the single-register read-only sensor model.
- Adds N data channels, read and write commands, burst transfers with address auto-increment, and a control register.
- Each channel produces pseudo-random readings from its own 8-bit LFSR.
- Used as a bus-functional target for SPI master blocks. Contains its own oversampled SPI shift logic; no external SPI core.

---
 rtl/multi_channel_spi_sensor.sv | 168 ++++++++++++++++
 tb/tb_multi_channel_spi_sensor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_spi_sensor.sv
// rtl/multi_channel_spi_sensor.sv - SPI mode-0 slave emulating a multi-channel sensor
module multi_channel_spi_sensor #(
    parameter int          NUM_CH       = 4,
    parameter logic [6:0]  DATA_BASE    = 7'h10,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h34,
    parameter logic [7:0]  SEED         = 8'h5A
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    output logic ctrl_en
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [6:0] ADDR_WHO  = 7'h0F;
    localparam logic [6:0] ADDR_CTRL = 7'h20;
    localparam int         IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [7:0] NUM_CH_W  = 8'(NUM_CH);

    function automatic logic [7:0] seed_of(input int i);
        logic [7:0] s;
        s = SEED ^ 8'(i);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    // Synchronisers are left unreset so a reset with cs held low cannot fake a cs fall.
    logic [1:0] cs_sync;
    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic       cs_d;
    logic       sck_d;

    always_ff @(posedge clk) begin
        cs_sync   <= {cs_sync[0], cs};
        sck_sync  <= {sck_sync[0], sck};
        mosi_sync <= {mosi_sync[0], mosi};
        cs_d      <= cs_sync[1];
        sck_d     <= sck_sync[1];
    end

    logic cs_s;
    logic mosi_s;
    logic cs_fall;
    logic sck_rise;
    logic sck_fall;

    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign cs_fall  = cs_d & ~cs_s;
    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;

    logic [1:0]  state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [6:0]  addr;
    logic [6:0]  tx_sr;
    logic [1:0]  ctrl;
    logic [7:0]  lfsr [NUM_CH];

    logic [7:0]       byte_now;
    logic             byte_done;
    logic [6:0]       load_addr;
    logic [6:0]       ch_off;
    logic             ch_hit;
    logic [IDX_W-1:0] ch_idx;
    logic [7:0]       rd_data;
    logic             load_rd;
    logic [7:0]       tx_byte;

    assign byte_now  = {shift_in, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != ST_IDLE) && !cs_s;
    // The command byte's own address is needed in the same cycle it completes.
    assign load_addr = (state == ST_CMD) ? byte_now[6:0] : addr;
    assign ch_off    = load_addr - DATA_BASE;
    assign ch_hit    = (load_addr >= DATA_BASE) && ({1'b0, ch_off} < NUM_CH_W);
    assign ch_idx    = ch_off[IDX_W-1:0];
    assign load_rd   = byte_done && (((state == ST_CMD) && byte_now[7]) || (state == ST_READ));
    assign tx_byte   = load_rd ? rd_data : 8'h00;
    assign ctrl_en   = ctrl[0];

    always_comb begin
        rd_data = 8'hEE;
        if (load_addr == ADDR_WHO) begin
            rd_data = WHO_AM_I_VAL;
        end else if (load_addr == ADDR_CTRL) begin
            rd_data = {6'b0, ctrl};
        end else if (ch_hit) begin
            rd_data = ctrl[0] ? lfsr[ch_idx] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                lfsr[i] <= seed_of(i);
            end else if (load_rd && ch_hit && ctrl[0] && (ch_idx == IDX_W'(i))) begin
                lfsr[i] <= lfsr_next(lfsr[i]);
            end
        end
    end

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic ai);
        return ai ? a + 7'd1 : a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            addr     <= 7'd0;
            tx_sr    <= 7'd0;
            miso     <= 1'b0;
            ctrl     <= 2'b11;
        end else if (cs_fall) begin
            state    <= ST_CMD;
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            tx_sr    <= 7'd0;
            miso     <= 1'b0;
        end else if (cs_s) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (sck_rise) begin
                shift_in <= byte_now[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    tx_sr <= tx_byte[6:0];
                    miso  <= tx_byte[7];
                    case (state)
                        ST_CMD: begin
                            addr  <= byte_now[7] ? addr_step(byte_now[6:0], ctrl[1]) : byte_now[6:0];
                            state <= byte_now[7] ? ST_READ : ST_WRITE;
                        end
                        ST_READ: begin
                            addr <= addr_step(addr, ctrl[1]);
                        end
                        default: begin
                            if (addr == ADDR_CTRL) begin
                                ctrl <= byte_now[1:0];
                            end
                            addr <= addr_step(addr, ctrl[1]);
                        end
                    endcase
                end
            end else if (sck_fall && (bit_cnt != 3'd0)) begin
                // The fall right after a byte load keeps the freshly loaded MSB.
                miso  <= tx_sr[6];
                tx_sr <= {tx_sr[5:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_spi_sensor.sv
// tb/tb_multi_channel_spi_sensor.sv - randomized bench with a register-level sensor model
module tb_multi_channel_spi_sensor;

    localparam int NUM_CH = 4;
    localparam int HALF   = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic miso;
    logic ctrl_en;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_no = 0;

    logic [7:0] tx_bytes  [8];
    logic [7:0] rx_bytes  [8];
    logic [7:0] exp_bytes [8];
    logic [7:0] lfsr_m    [NUM_CH];
    logic [1:0] ctrl_m;

    multi_channel_spi_sensor #(
        .NUM_CH(NUM_CH),
        .DATA_BASE(7'h10),
        .WHO_AM_I_VAL(8'h34),
        .SEED(8'h5A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .sck(sck),
        .mosi(mosi),
        .miso(miso),
        .ctrl_en(ctrl_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic m_reset();
        ctrl_m = 2'b11;
        for (int i = 0; i < NUM_CH; i++) begin
            lfsr_m[i] = 8'h5A ^ 8'(i);
            if (lfsr_m[i] == 8'h00) lfsr_m[i] = 8'h01;
        end
    endtask

    task automatic m_read(input logic [6:0] a, output logic [7:0] v);
        int ai;
        ai = int'(a);
        if (a == 7'h0F) v = 8'h34;
        else if (a == 7'h20) v = {6'b0, ctrl_m};
        else if (ai >= 16 && ai < 16 + NUM_CH) begin
            if (ctrl_m[0]) begin
                v = lfsr_m[ai - 16];
                lfsr_m[ai - 16] = m_step(v);
            end else begin
                v = 8'h00;
            end
        end else v = 8'hEE;
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = b[7 - i];
            #HALF;
            r[7 - i] = miso;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    // n complete data bytes, then pbits of a further byte before cs rises.
    task automatic run_frame(input logic [7:0] cmd, input int n, input int pbits);
        logic [6:0] a;
        logic [7:0] v;
        logic       ai_now;
        logic [7:0] dummy;
        frame_no++;
        a = cmd[6:0];
        for (int k = 0; k < 8; k++) exp_bytes[k] = 8'h00;
        if (cmd[7]) begin
            for (int j = 0; j <= n; j++) begin
                m_read(a, v);
                if (j + 1 < 8) exp_bytes[j + 1] = v;
                a = ctrl_m[1] ? a + 7'd1 : a;
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                ai_now = ctrl_m[1];
                if (a == 7'h20) ctrl_m = tx_bytes[k][1:0];
                a = ai_now ? a + 7'd1 : a;
            end
        end
        cs = 1'b0;
        #100;
        xfer_bits(cmd, 8, rx_bytes[0]);
        for (int k = 1; k <= n; k++) xfer_bits(tx_bytes[k], 8, rx_bytes[k]);
        if (pbits > 0) xfer_bits(tx_bytes[n + 1], pbits, dummy);
        #HALF;
        cs = 1'b1;
        #100;
        for (int k = 0; k <= n; k++)
            check($sformatf("frame%0d cmd%h byte%0d", frame_no, cmd, k), rx_bytes[k], exp_bytes[k]);
        check($sformatf("frame%0d ctrl_en", frame_no), {7'b0, ctrl_en}, {7'b0, ctrl_m[0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_reset();
        #100;
    endtask

    initial begin
        logic [7:0] r;
        logic [6:0] a;
        int         kind;
        int         n;
        int         pb;
        m_reset();
        for (int k = 0; k < 8; k++) tx_bytes[k] = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #100;
        check("reset miso", {7'b0, miso}, 8'h00);
        check("reset ctrl_en", {7'b0, ctrl_en}, 8'h01);

        run_frame(8'h8F, 1, 0);
        check("who_am_i", rx_bytes[1], 8'h34);

        do_reset();
        run_frame(8'h90, 3, 0);
        check("burst ch0", rx_bytes[1], 8'h5A);
        check("burst ch1", rx_bytes[2], 8'h5B);
        check("burst ch2", rx_bytes[3], 8'h58);
        run_frame(8'h90, 1, 0);
        check("ch0 second", rx_bytes[1], 8'h2D);

        do_reset();
        tx_bytes[1] = 8'h01;
        run_frame(8'h20, 1, 0);
        run_frame(8'h90, 3, 0);
        check("held ch0 a", rx_bytes[1], 8'h5A);
        check("held ch0 b", rx_bytes[2], 8'h2D);
        check("held ch0 c", rx_bytes[3], 8'hAE);

        do_reset();
        tx_bytes[1] = 8'h02;
        run_frame(8'h20, 1, 0);
        check("disabled ctrl_en", {7'b0, ctrl_en}, 8'h00);
        run_frame(8'h91, 1, 0);
        check("disabled ch1", rx_bytes[1], 8'h00);
        tx_bytes[1] = 8'h03;
        run_frame(8'h20, 1, 0);
        run_frame(8'h91, 1, 0);
        check("reenabled ch1", rx_bytes[1], 8'h5B);

        run_frame(8'hFF, 2, 0);
        check("addr 7f", rx_bytes[1], 8'hEE);
        check("addr wrap 00", rx_bytes[2], 8'hEE);
        tx_bytes[1] = 8'hFF;
        run_frame(8'h0F, 1, 0);
        run_frame(8'h8F, 1, 0);
        check("who_am_i after write", rx_bytes[1], 8'h34);

        tx_bytes[1] = 8'h00;
        run_frame(8'h20, 0, 4);
        run_frame(8'hA0, 1, 0);
        check("ctrl after abort", rx_bytes[1], 8'h03);

        // Reset in the middle of a read frame, with cs still low.
        cs = 1'b0;
        #100;
        xfer_bits(8'h90, 8, r);
        xfer_bits(8'h00, 4, r);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        check("midreset miso", {7'b0, miso}, 8'h00);
        check("midreset ctrl_en", {7'b0, ctrl_en}, 8'h01);
        xfer_bits(8'hA5, 8, r);
        check("ignored frame miso", r, 8'h00);
        #HALF;
        cs = 1'b1;
        #100;
        run_frame(8'h90, 3, 0);
        check("post reset ch0", rx_bytes[1], 8'h5A);
        check("post reset ch2", rx_bytes[3], 8'h58);

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if (kind < 6) begin
                case ($urandom_range(0, 4))
                    0: a = 7'h0F;
                    1: a = 7'h20;
                    2, 3: a = 7'h10 + 7'($urandom_range(0, NUM_CH - 1));
                    default: a = 7'($urandom);
                endcase
                n = $urandom_range(0, 4);
                run_frame({1'b1, a}, n, pb);
            end else if (kind < 8) begin
                if ($urandom_range(0, 3) != 0) tx_bytes[1][0] = 1'b1;
                run_frame(8'h20, 1, pb);
            end else begin
                run_frame({1'b0, 7'($urandom)}, 1, pb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
